// File: rtl/axis_to_axi4_burst_writer_pkg.sv
// Shared AXI constants, FSM state encoding and the beat-size helper
// for the stream-to-AXI4 burst writer.
package axi_stream_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int unsigned BOUNDARY_4K = 32'd4096;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Data bus width in bits to log2 of its byte count (32 -> 2, 64 -> 3).
  function automatic int unsigned size_log2(input int unsigned data_width);
    int unsigned res;
    case (data_width)
      32'd64:  res = 32'd3;
      32'd32:  res = 32'd2;
      default: res = 32'd2;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/axis_to_axi4_burst_writer_if.sv
// Command, stream and AXI4 write-channel bundle; master is the writer,
// slave is whatever drives the command/stream and answers the bus.
interface axis_to_axi4_burst_writer_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int COUNT_WIDTH    = 16
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr;
  logic [COUNT_WIDTH-1:0]      cmd_words;
  logic                        busy;
  logic                        done;
  logic                        err;
  logic [AXI_DATA_WIDTH-1:0]   s_axis_tdata;
  logic                        s_axis_tvalid;
  logic                        s_axis_tready;
  logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]                  m_axi_awlen;
  logic [2:0]                  m_axi_awsize;
  logic [1:0]                  m_axi_awburst;
  logic [AXI_ID_WIDTH-1:0]     m_axi_awid;
  logic                        m_axi_awvalid;
  logic                        m_axi_awready;
  logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                        m_axi_wlast;
  logic                        m_axi_wvalid;
  logic                        m_axi_wready;
  logic [1:0]                  m_axi_bresp;
  logic [AXI_ID_WIDTH-1:0]     m_axi_bid;
  logic                        m_axi_bvalid;
  logic                        m_axi_bready;
  logic                        Activity;

  modport master (
    input  cmd_valid, cmd_addr, cmd_words, s_axis_tdata, s_axis_tvalid,
           m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bid, m_axi_bvalid,
    output cmd_ready, busy, done, err, s_axis_tready,
           m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid,
           m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
           m_axi_bready, Activity
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_words, s_axis_tdata, s_axis_tvalid,
           m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bid, m_axi_bvalid,
    input  cmd_ready, busy, done, err, s_axis_tready,
           m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid,
           m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
           m_axi_bready, Activity
  );
endinterface

// File: rtl/axis_to_axi4_burst_writer_splitter.sv
// Burst sizing: beats = min(remaining, MAX_BURST, words left in the 4 KB page),
// captured on load; next_addr is the base of the following burst.
module axi_burst_splitter
  import axi_stream_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_BURST      = 16,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      load,
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  input  logic [COUNT_WIDTH-1:0]    remaining,
  output logic [8:0]                beats_now,
  output logic [8:0]                beats,
  output logic [AXI_ADDR_WIDTH-1:0] next_addr
);
  localparam int unsigned SIZE = size_log2(AXI_DATA_WIDTH);

  logic [12:0] bytes_to_4k_s;
  logic [12:0] words_to_4k_s;
  logic [31:0] rem_s;
  logic [31:0] cap_s;
  logic [8:0]  beats_r;

  // Beat count for a burst starting at addr.
  always_comb begin
    bytes_to_4k_s = 13'(BOUNDARY_4K) - {1'b0, addr[11:0]};
    words_to_4k_s = bytes_to_4k_s >> SIZE;
    rem_s         = 32'(remaining);
    cap_s         = (rem_s > 32'(MAX_BURST)) ? 32'(MAX_BURST) : rem_s;
    beats_now     = (cap_s > 32'(words_to_4k_s)) ? 9'(words_to_4k_s) : 9'(cap_s);
  end

  // Hold the beat count of the burst in flight.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beats_r <= 9'd0;
    end else if (load) begin
      beats_r <= beats_now;
    end else begin
      beats_r <= beats_r;
    end
  end

  assign beats     = beats_r;
  assign next_addr = addr + (AXI_ADDR_WIDTH'(beats_r) << SIZE);

endmodule

// File: rtl/axis_to_axi4_burst_writer.sv
// AXI4 write master: drains an AXI4-Stream into memory as INCR bursts for one
// (address, word count) command, reporting done and a sticky bresp error.
module axis_to_axi4_burst_writer
  import axi_stream_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int MAX_BURST      = 16,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  axis_to_axi4_burst_writer_if.master   bus
);
  localparam int unsigned SIZE = size_log2(AXI_DATA_WIDTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK = AXI_ADDR_WIDTH'((32'd1 << SIZE) - 32'd1);

  state_t                    state_r;
  logic [AXI_ADDR_WIDTH-1:0] addr_r;
  logic [COUNT_WIDTH-1:0]    remaining_r;
  logic [8:0]                beat_cnt_r;
  logic                      zero_pend_r;
  logic                      cmd_ready_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      err_r;
  logic                      activity_r;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_r;
  logic [7:0]                awlen_r;
  logic                      awvalid_r;
  logic [AXI_DATA_WIDTH-1:0] wdata_r;
  logic                      wvalid_r;
  logic                      wlast_r;
  logic                      bready_r;
  logic                      tready_r;
  logic [8:0]                beats_now_s;
  logic [8:0]                beats_s;
  logic [AXI_ADDR_WIDTH-1:0] next_addr_s;

  axi_burst_splitter #(
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .MAX_BURST      (MAX_BURST),
    .COUNT_WIDTH    (COUNT_WIDTH)
  ) u_splitter (
    .aclk      (aclk),
    .areset    (areset),
    .load      (state_r == ST_CALC),
    .addr      (addr_r),
    .remaining (remaining_r),
    .beats_now (beats_now_s),
    .beats     (beats_s),
    .next_addr (next_addr_s)
  );

  // Command / burst / beat sequencing with all outputs registered.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r     <= ST_IDLE;
      addr_r      <= {AXI_ADDR_WIDTH{1'b0}};
      remaining_r <= {COUNT_WIDTH{1'b0}};
      beat_cnt_r  <= 9'd0;
      zero_pend_r <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      activity_r  <= 1'b0;
      awaddr_r    <= {AXI_ADDR_WIDTH{1'b0}};
      awlen_r     <= 8'd0;
      awvalid_r   <= 1'b0;
      wdata_r     <= {AXI_DATA_WIDTH{1'b0}};
      wvalid_r    <= 1'b0;
      wlast_r     <= 1'b0;
      bready_r    <= 1'b0;
      tready_r    <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      activity_r <= (bus.s_axis_tvalid & tready_r) | (wvalid_r & bus.m_axi_wready);
      case (state_r)
        ST_IDLE: begin
          if (zero_pend_r) begin
            // Zero-word command: finish without touching the bus.
            zero_pend_r <= 1'b0;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
          end else if (bus.cmd_valid && cmd_ready_r) begin
            addr_r      <= bus.cmd_addr & ~LOW_MASK;
            remaining_r <= bus.cmd_words;
            err_r       <= 1'b0;
            busy_r      <= 1'b1;
            cmd_ready_r <= 1'b0;
            if (bus.cmd_words == {COUNT_WIDTH{1'b0}}) begin
              zero_pend_r <= 1'b1;
            end else begin
              state_r <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          awaddr_r  <= addr_r;
          awlen_r   <= 8'(beats_now_s - 9'd1);
          awvalid_r <= 1'b1;
          state_r   <= ST_ADDR;
        end
        ST_ADDR: begin
          if (awvalid_r && bus.m_axi_awready) begin
            awvalid_r  <= 1'b0;
            beat_cnt_r <= beats_s;
            tready_r   <= 1'b1;
            state_r    <= ST_DATA;
          end
        end
        ST_DATA: begin
          // Single holding register: tready and wvalid are never high together.
          if (tready_r && bus.s_axis_tvalid) begin
            wdata_r  <= bus.s_axis_tdata;
            tready_r <= 1'b0;
            wvalid_r <= 1'b1;
            wlast_r  <= (beat_cnt_r == 9'd1);
          end else if (wvalid_r && bus.m_axi_wready) begin
            wvalid_r   <= 1'b0;
            wlast_r    <= 1'b0;
            beat_cnt_r <= beat_cnt_r - 9'd1;
            if (beat_cnt_r != 9'd1) begin
              tready_r <= 1'b1;
            end else begin
              bready_r <= 1'b1;
              state_r  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (bready_r && bus.m_axi_bvalid) begin
            bready_r    <= 1'b0;
            if (bus.m_axi_bresp != RESP_OKAY) begin
              err_r <= 1'b1;
            end
            addr_r      <= next_addr_s;
            remaining_r <= remaining_r - COUNT_WIDTH'(beats_s);
            if (remaining_r != COUNT_WIDTH'(beats_s)) begin
              state_r <= ST_CALC;
            end else begin
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
              cmd_ready_r <= 1'b1;
              state_r     <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cmd_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready     = cmd_ready_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.err           = err_r;
  assign bus.Activity      = activity_r;
  assign bus.s_axis_tready = tready_r;
  assign bus.m_axi_awaddr  = awaddr_r;
  assign bus.m_axi_awlen   = awlen_r;
  assign bus.m_axi_awsize  = 3'(SIZE);
  assign bus.m_axi_awburst = BURST_INCR;
  assign bus.m_axi_awid    = {AXI_ID_WIDTH{1'b0}};
  assign bus.m_axi_awvalid = awvalid_r;
  assign bus.m_axi_wdata   = wdata_r;
  assign bus.m_axi_wstrb   = {(AXI_DATA_WIDTH/8){1'b1}};
  assign bus.m_axi_wlast   = wlast_r;
  assign bus.m_axi_wvalid  = wvalid_r;
  assign bus.m_axi_bready  = bready_r;

endmodule

// File: tb/tb_axis_to_axi4_burst_writer.sv
// Directed bench: a queue-based burst model predicts AW/W traffic, a per-cycle
// monitor drives the stream/AXI responder and compares each handshake.
module tb_axis_to_axi4_burst_writer;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int MB = 16;
  localparam int CW = 16;

  logic aclk = 1'b0;
  logic areset = 1'b0;
  always #5 aclk = ~aclk;

  axis_to_axi4_burst_writer_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW),
                                 .AXI_ID_WIDTH(IW), .COUNT_WIDTH(CW)) bus ();

  axis_to_axi4_burst_writer #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW),
                              .MAX_BURST(MB), .COUNT_WIDTH(CW)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_aw_addr[$];
  logic [7:0]  exp_aw_len[$];
  logic [31:0] exp_w_data[$];
  logic        exp_w_last[$];
  logic [31:0] src_q[$];
  logic [31:0] log_aw_addr[$];
  logic [7:0]  log_aw_len[$];

  bit random_mode = 1'b0;
  int err_burst = -1;
  int b_idx = 0;
  int pending_b = 0;
  int w_hs_count = 0;
  int t_hs_count = 0;
  bit t_hold, b_hold, aw_stall, w_stall, prev_act;
  logic [31:0] aw_stall_addr, w_stall_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Burst plan straight from the rules: min(remaining, 16, words to next 4 KB page).
  task automatic model_cmd(input logic [31:0] addr, input int words, input logic [31:0] first);
    logic [31:0] a;
    int rem, room, b;
    a = addr & 32'hFFFF_FFFC;
    rem = words;
    while (rem > 0) begin
      room = (4096 - int'(a % 32'd4096)) / 4;
      b = rem;
      if (b > MB) b = MB;
      if (b > room) b = room;
      exp_aw_addr.push_back(a);
      exp_aw_len.push_back(8'(b - 1));
      for (int i = 0; i < b; i++) exp_w_last.push_back(i == b - 1);
      a = a + 32'(b * 4);
      rem -= b;
    end
    for (int i = 0; i < words; i++) begin
      exp_w_data.push_back(first + 32'(i));
      src_q.push_back(first + 32'(i));
    end
  endtask

  // Responder and monitor: drive inputs for the next edge, then score the handshakes they make.
  always @(negedge aclk) begin
    bit t_hs, w_hs, aw_hs, b_hs;
    if (areset) begin
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = 32'd0;
      bus.m_axi_awready = 1'b0;
      bus.m_axi_wready  = 1'b0;
      bus.m_axi_bvalid  = 1'b0;
      bus.m_axi_bresp   = 2'b00;
      bus.m_axi_bid     = 8'd0;
      t_hold = 1'b0; b_hold = 1'b0; aw_stall = 1'b0; w_stall = 1'b0; prev_act = 1'b0;
      pending_b = 0; w_hs_count = 0; t_hs_count = 0;
    end else begin
      chk("activity", bus.Activity, prev_act);
      if (aw_stall) begin
        chk("aw_valid_held", bus.m_axi_awvalid, 1);
        chk("aw_addr_held", bus.m_axi_awaddr, aw_stall_addr);
      end
      if (w_stall) begin
        chk("w_valid_held", bus.m_axi_wvalid, 1);
        chk("w_data_held", bus.m_axi_wdata, w_stall_data);
      end
      if (!t_hold) begin
        bus.s_axis_tvalid = (src_q.size() > 0) && (!random_mode || $urandom_range(0, 2) != 0);
        if (src_q.size() > 0) bus.s_axis_tdata = src_q[0];
      end
      bus.m_axi_wready  = !random_mode || ($urandom_range(0, 2) != 0);
      bus.m_axi_awready = !random_mode || ($urandom_range(0, 2) != 0);
      if (!b_hold) begin
        bus.m_axi_bvalid = (pending_b > 0) && (!random_mode || $urandom_range(0, 1) != 0);
        bus.m_axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
      end
      t_hs  = bus.s_axis_tvalid && bus.s_axis_tready;
      w_hs  = bus.m_axi_wvalid && bus.m_axi_wready;
      aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
      b_hs  = bus.m_axi_bvalid && bus.m_axi_bready;
      if (aw_hs) begin
        log_aw_addr.push_back(bus.m_axi_awaddr);
        log_aw_len.push_back(bus.m_axi_awlen);
        if (exp_aw_addr.size() == 0) begin
          chk("aw_unexpected", 1, 0);
        end else begin
          chk("awaddr", bus.m_axi_awaddr, exp_aw_addr.pop_front());
          chk("awlen", bus.m_axi_awlen, exp_aw_len.pop_front());
          chk("awburst", bus.m_axi_awburst, 2'b01);
        end
      end
      if (t_hs) begin
        chk("stream_ahead_of_w", t_hs_count - w_hs_count, 0);
        void'(src_q.pop_front());
        t_hs_count++;
      end
      if (w_hs) begin
        if (exp_w_data.size() == 0) begin
          chk("w_unexpected", 1, 0);
        end else begin
          chk("wdata", bus.m_axi_wdata, exp_w_data.pop_front());
          chk("wlast", bus.m_axi_wlast, exp_w_last.pop_front());
          chk("wstrb", bus.m_axi_wstrb, 4'hF);
        end
        w_hs_count++;
        if (bus.m_axi_wlast) pending_b++;
      end
      if (b_hs) begin
        pending_b--;
        b_idx++;
      end
      t_hold = bus.s_axis_tvalid && !t_hs;
      b_hold = bus.m_axi_bvalid && !b_hs;
      aw_stall = bus.m_axi_awvalid && !bus.m_axi_awready;
      aw_stall_addr = bus.m_axi_awaddr;
      w_stall = bus.m_axi_wvalid && !bus.m_axi_wready;
      w_stall_data = bus.m_axi_wdata;
      prev_act = t_hs || w_hs;
    end
  end

  task automatic issue_cmd(input logic [31:0] addr, input int words);
    int n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_words = 16'(words);
    @(negedge aclk);
    bus.cmd_valid = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    chk("cmd_ready_after_accept", bus.cmd_ready, 0);
    chk("err_cleared_on_accept", bus.err, 0);
  endtask

  task automatic run_cmd(input logic [31:0] addr, input int words, input logic [31:0] first,
                         input int eb, input bit exp_err);
    int cyc = 0;
    err_burst = eb;
    b_idx = 0;
    log_aw_addr.delete();
    log_aw_len.delete();
    model_cmd(addr, words, first);
    issue_cmd(addr, words);
    while (!bus.done && cyc < 3000) begin
      @(negedge aclk);
      cyc++;
    end
    chk("done_seen", bus.done, 1);
    if (words == 0) chk("zero_done_latency", cyc, 1);
    chk("busy_at_done", bus.busy, 0);
    chk("err_at_done", bus.err, exp_err);
    chk("aw_all_issued", exp_aw_addr.size(), 0);
    chk("w_all_written", exp_w_data.size(), 0);
    @(negedge aclk);
    chk("done_one_cycle", bus.done, 0);
    chk("cmd_ready_after_done", bus.cmd_ready, 1);
  endtask

  initial begin
    int base, n;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.cmd_words = 16'd0;
    #1 areset = 1'b1;
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_awvalid", bus.m_axi_awvalid, 0);
    chk("rst_wvalid", bus.m_axi_wvalid, 0);
    chk("rst_tready", bus.s_axis_tready, 0);
    chk("rst_bready", bus.m_axi_bready, 0);
    chk("rst_activity", bus.Activity, 0);
    chk("awsize_const", bus.m_axi_awsize, 3'd2);
    chk("awid_const", bus.m_axi_awid, 8'd0);
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);

    run_cmd(32'h1000, 16, 32'd1, -1, 1'b0);
    chk("t1_aw_count", log_aw_addr.size(), 1);
    chk("t1_aw0_addr", log_aw_addr[0], 32'h1000);
    chk("t1_aw0_len", log_aw_len[0], 8'd15);

    run_cmd(32'h1000, 40, 32'h100, -1, 1'b0);
    chk("t2_aw_count", log_aw_addr.size(), 3);
    chk("t2_aw1_addr", log_aw_addr[1], 32'h1040);
    chk("t2_aw2_addr", log_aw_addr[2], 32'h1080);
    chk("t2_aw2_len", log_aw_len[2], 8'd7);

    run_cmd(32'h1FF8, 8, 32'h200, -1, 1'b0);
    chk("t3_aw_count", log_aw_addr.size(), 2);
    chk("t3_aw0_len", log_aw_len[0], 8'd1);
    chk("t3_aw1_addr", log_aw_addr[1], 32'h2000);
    chk("t3_aw1_len", log_aw_len[1], 8'd5);

    run_cmd(32'h0, 40, 32'h300, 1, 1'b1);
    chk("t4_aw_count", log_aw_addr.size(), 3);

    run_cmd(32'h0, 0, 32'h0, -1, 1'b0);
    chk("t5_no_aw", log_aw_addr.size(), 0);

    random_mode = 1'b1;
    run_cmd(32'h0FF0, 30, 32'h400, 2, 1'b1);
    chk("t6_aw_count", log_aw_addr.size(), 3);
    chk("t6_aw0_len", log_aw_len[0], 8'd3);
    chk("t6_aw1_addr", log_aw_addr[1], 32'h1000);
    chk("t6_aw2_len", log_aw_len[2], 8'd9);
    random_mode = 1'b0;

    // Abandon a burst mid-data with an asynchronous reset.
    err_burst = -1;
    b_idx = 0;
    model_cmd(32'h3000, 40, 32'h500);
    issue_cmd(32'h3000, 40);
    base = w_hs_count;
    n = 0;
    while (w_hs_count - base < 5 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    chk("t7_reached_data", (w_hs_count - base) >= 5, 1);
    #2 areset = 1'b1;
    #1;
    chk("t7_awvalid", bus.m_axi_awvalid, 0);
    chk("t7_wvalid", bus.m_axi_wvalid, 0);
    chk("t7_tready", bus.s_axis_tready, 0);
    chk("t7_busy", bus.busy, 0);
    chk("t7_cmd_ready", bus.cmd_ready, 1);
    exp_aw_addr.delete(); exp_aw_len.delete();
    exp_w_data.delete(); exp_w_last.delete(); src_q.delete();
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);

    run_cmd(32'h2002, 5, 32'h600, -1, 1'b0);
    chk("t8_aw_count", log_aw_addr.size(), 1);
    chk("t8_aw0_addr", log_aw_addr[0], 32'h2000);
    chk("t8_aw0_len", log_aw_len[0], 8'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_to_axi4_burst_writer.md
Name: axis_to_axi4_burst_writer

Overview:
- AXI4 burst-write master: drains an AXI4-Stream into memory as INCR write bursts.
- Counterpart to the slave-side stream bridge. That bridge is an AXI4 responder fed by a DMA; this block is the initiator, so the FPGA moves stream data, e.g. DDC samples, into PS/DDR memory without an external DMA.
- Software or a control FSM issues one command (base address, word count). The block splits it into bursts and reports done/error.

Parameters:
- AXI_DATA_WIDTH, 32, data bus and stream width; must be 32 or 64.
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_ID_WIDTH, 8, AXI ID width.
- MAX_BURST, 16, maximum beats per burst; range 1..256.
- COUNT_WIDTH, 16, width of the command word count.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when idle and able to accept a command.
- cmd_addr  in  AXI_ADDR_WIDTH  start byte address; low log2(bytes) bits are ignored (forced 0).
- cmd_words  in  COUNT_WIDTH  number of data words to write.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle pulse when the command completes.
- err  out  1  sticky; set by any non-OKAY bresp; cleared on next command accept.
- s_axis_tdata  in  AXI_DATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready (registered).
- m_axi_awaddr / awlen[7:0] / awsize[2:0] / awburst[1:0] / awid / awvalid  out  write address channel.
- m_axi_awready  in  1.
- m_axi_wdata / wstrb / wlast / wvalid  out  write data channel.
- m_axi_wready  in  1.
- m_axi_bresp[1:0] / bid / bvalid  in  write response channel.
- m_axi_bready  out  1.
- Activity  out  1  registered; high the cycle after any stream or W handshake.

Behaviour:
- Timing rules:
  - All outputs are registered; no combinational path from any input to any output.
  - awid fixed 0; awburst = 2'b01 (INCR); awsize = log2(AXI_DATA_WIDTH/8); wstrb all ones.
- Reset (areset high, asynchronous):
  - Outputs 0: awvalid, wvalid, wlast, bready, s_axis_tready, busy, done, err, Activity, awaddr, awlen, wdata.
  - cmd_ready = 1; FSM = IDLE.
  - Reset mid-burst abandons the transaction immediately; no completion is attempted.
- FSM states: IDLE, CALC, ADDR, DATA, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch address and count, clear err, busy = 1, cmd_ready = 0.
  - Count 0: done pulses the next cycle, busy returns to 0, state stays IDLE, no bus activity.
  - Otherwise go to CALC.
- CALC: compute beats = min(remaining, MAX_BURST, words_to_4k).
  - words_to_4k = (4096 - addr[11:0]) >> log2(bytes).
  - Bursts never cross a 4 KB boundary.
  - Load awaddr and awlen = beats-1; assert awvalid; go to ADDR.
- ADDR: on awvalid & awready, drop awvalid, load the beat counter, assert s_axis_tready, go to DATA.
- DATA uses a single-entry holding register:
  - On s_axis_tvalid & s_axis_tready: latch wdata, drop tready, assert wvalid; wlast = 1 if this is the final beat of the burst.
  - On wvalid & wready: drop wvalid and wlast, decrement the beat counter. If beats remain, reassert tready; else go to RESP with bready = 1.
  - Throughput: one beat per two clocks at best.
  - No stream word is accepted beyond the beats of the current burst.
- RESP: on bvalid & bready:
  - Drop bready; bresp != 0 sets err.
  - addr += beats*bytes; remaining -= beats.
  - remaining != 0: go to CALC. Else done pulses 1 cycle, busy = 0, go to IDLE.
  - An error does not abort; remaining bursts still execute.
- Stalls: tvalid low or wready low holds state indefinitely; valids never drop before handshake.
- Width/arithmetic rules:
  - Address arithmetic is AXI_ADDR_WIDTH with wrap modulo 2^AXI_ADDR_WIDTH.
  - remaining is COUNT_WIDTH wide; beats is 9 bits to hold 256.
- cmd_valid while busy is ignored (cmd_ready = 0).

Decomposition:
- Package axi_stream_pkg holds:
  - AXI constants: BURST_INCR = 2'b01, RESP_OKAY = 2'b00, BOUNDARY_4K = 4096.
  - FSM state enum.
  - log2 byte-size function.
- Natural sub-module: axi_burst_splitter. Combinational plus a register; given addr, remaining and MAX_BURST it produces beats and next_addr. It is unit-testable alone for 4 KB and short-tail cases.

Test Plan:
- MAX_BURST=16; cmd 0x1000 / 16 words, stream data 1..16 -> one AW 0x1000 awlen 15; 16 W beats with data 1..16, wlast only on beat 16; done pulse after B.
- cmd 0x1000 / 40 words -> AWs at 0x1000 (awlen 15), 0x1040 (15), 0x1080 (7); 40 beats in order; single done.
- cmd 0x1FF8 / 8 words -> AW 0x1FF8 awlen 1, then AW 0x2000 awlen 5; no burst crosses 0x2000.
- cmd 0x0 / 40 words, bresp 2'b10 on burst 2 -> all 3 bursts complete, err = 1 at done; the next cmd accept clears err.
- cmd_words 0 -> done one cycle after accept; awvalid never asserted; cmd_ready back to 1.
- Random tvalid gaps and wready/awready/bvalid backpressure -> data order preserved, valids stable until handshake. Assert areset mid-DATA -> awvalid, wvalid, s_axis_tready and busy go to 0 without waiting for a clock edge; cmd_ready = 1.
